// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store bridge.
//   - request size encodings
//   - bridge state enum
//   - misalignment check used at request acceptance
package lsu_pkg;

  localparam logic [1:0] LSU_SZ_BYTE = 2'd0;
  localparam logic [1:0] LSU_SZ_HALF = 2'd1;
  localparam logic [1:0] LSU_SZ_WORD = 2'd2;
  localparam logic [1:0] LSU_SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_ACC1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_t;

  // An access is misaligned when its lanes run past lane 3 of the word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == LSU_SZ_HALF) && (off == 2'd3)) ||
           ((size == LSU_SZ_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane alignment for the load/store bridge.
// Ports:
//   off, size, is_unsigned  - captured request offset, size, extension mode
//   wdata                   - right-justified store data
//   be_lo / be_hi           - byte enables for first / spilled second access
//   wdata_lo / wdata_hi     - lane-aligned store data for first / second access
//   rdata_lo / rdata_hi     - memory words returned by first / second access
//   rdata                   - extracted and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [31:0] rdata
);

  logic [7:0]  be_base;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [31:0] rdata_shift;
  logic [5:0]  shamt;

  assign shamt = {1'b0, off, 3'b000};

  always_comb begin
    be_base = 8'b0000_0000;
    case (size)
      LSU_SZ_BYTE: be_base = 8'b0000_0001;
      LSU_SZ_HALF: be_base = 8'b0000_0011;
      LSU_SZ_WORD: be_base = 8'b0000_1111;
      default:     be_base = 8'b0000_0000;
    endcase
  end

  // Shifting across a 64-bit window lets the spill lanes fall out naturally.
  assign be_wide    = be_base << off;
  assign be_lo      = be_wide[3:0];
  assign be_hi      = be_wide[7:4];
  assign wdata_wide = {32'h0, wdata} << shamt;
  assign wdata_lo   = wdata_wide[31:0];
  assign wdata_hi   = wdata_wide[63:32];

  assign rdata_shift = 32'({rdata_hi, rdata_lo} >> shamt);

  always_comb begin
    rdata = 32'h0;
    case (size)
      LSU_SZ_BYTE: rdata = is_unsigned ? {24'h0, rdata_shift[7:0]}
                                       : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      LSU_SZ_HALF: rdata = is_unsigned ? {16'h0, rdata_shift[15:0]}
                                       : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      LSU_SZ_WORD: rdata = rdata_shift;
      default:     rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_bridge.sv
// lsu_bridge: converts byte/half/word core accesses at any byte address into
// word-aligned memory accesses with byte enables; extracts and extends loads.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN
//   defined     - misaligned accesses are split into two word accesses
//   not defined - misaligned accesses are rejected with resp_err
// Ports:
//   clk, rst                               - clock, async active-high reset
//   req_valid/ready/we/size/unsigned/addr/wdata - core request
//   resp_valid/rdata/err                   - one-cycle completion
//   mem_valid/ready/we/addr/be/wdata       - memory request channel
//   mem_rvalid/rdata                       - memory read return
module lsu_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t state, state_next;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_word;
  logic              acc_err;
  logic              split;

  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [3:0]        be_lo, be_hi;
  logic [31:0]       wdata_lo, wdata_hi;
  logic [31:0]       load_data;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        split_q;
  logic [31:0] hi_q;
  assign acc_err = (req_size == LSU_SZ_ILL);
  assign split   = split_q;
  assign hi_word = hi_q;
`else
  assign acc_err = (req_size == LSU_SZ_ILL) || is_misaligned(req_size, req_addr[1:0]);
  assign split   = 1'b0;
  assign hi_word = 32'h0;
`endif

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign next_addr = word_addr + ADDR_W'(4);

  lsu_align u_align (
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .be_lo       (be_lo),
    .be_hi       (be_hi),
    .wdata_lo    (wdata_lo),
    .wdata_hi    (wdata_hi),
    .rdata_lo    (lo_q),
    .rdata_hi    (hi_word),
    .rdata       (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      lo_q    <= 32'h0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q <= 1'b0;
      hi_q    <= 32'h0;
`endif
    end else begin
      if (state == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= acc_err;
`ifdef LSU_MISALIGNED_SPLIT_EN
        split_q <= is_misaligned(req_size, req_addr[1:0]);
`endif
      end
      if (state == ST_WAIT0 && mem_rvalid) lo_q <= mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (state == ST_WAIT1 && mem_rvalid) hi_q <= mem_rdata;
`endif
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'h0;
    mem_wdata  = 32'h0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = acc_err ? ST_RESP : ST_ACC0;
      end
      ST_ACC0: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr;
        mem_be    = be_lo;
        mem_wdata = wdata_lo;
        if (mem_ready) begin
          if (!we_q)      state_next = ST_WAIT0;
          else if (split) state_next = ST_ACC1;
          else            state_next = ST_RESP;
        end
      end
      ST_WAIT0: begin
        if (mem_rvalid) state_next = split ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = next_addr;
        mem_be    = be_hi;
        mem_wdata = wdata_hi;
        if (mem_ready) state_next = we_q ? ST_RESP : ST_WAIT1;
      end
      ST_WAIT1: begin
        if (mem_rvalid) state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'h0 : load_data;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_bridge.sv
module tb_lsu_bridge;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_outs", {resp_valid, resp_err, mem_valid, mem_we, mem_be},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("rst_data", {resp_rdata, mem_wdata}, 64'h0);
    chk("rst_addr", mem_addr, 0);
    step();
    rst = 1'b0;
    step();

    // aligned word store, mem_ready immediately
    issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF);
    chk("st_ready", req_ready, 1);
    step();                                   // cycle 1
    req_valid = 0; mem_ready = 1;
    chk("st_mvalid", mem_valid, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h100);
    chk("st_be", mem_be, 4'hF);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    step();                                   // cycle 2
    mem_ready = 0;
    chk("st_resp", {resp_valid, resp_err}, 2'b10);
    chk("st_rdata", resp_rdata, 0);
    chk("st_mvalid_off", mem_valid, 0);
    step();                                   // cycle 3
    chk("st_idle", {req_ready, resp_valid}, 2'b10);

    // signed byte load at 0x203, memory stalls one cycle
    issue(0, 2'd0, 0, 32'h203, 32'h0);
    step();                                   // ACC0, not ready yet
    req_valid = 0;
    chk("lb_addr", mem_addr, 32'h200);
    chk("lb_be", {mem_valid, mem_we, mem_be}, {1'b1, 1'b0, 4'h8});
    step();                                   // ACC0 held
    mem_ready = 1;
    chk("lb_hold", {mem_valid, mem_addr, mem_be}, {1'b1, 32'h200, 4'h8});
    step();                                   // WAIT0
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h80FFFFFF;
    chk("lb_wait", {resp_valid, mem_valid}, 2'b00);
    step();
    mem_rvalid = 0;
    chk("lb_resp", {resp_valid, resp_err}, 2'b10);
    chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
    step();

    // unsigned byte load; rvalid with mem_ready must be ignored
    issue(0, 2'd0, 1, 32'h203, 32'h0);
    step();
    req_valid = 0; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h12345678;
    step();                                   // WAIT0
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h80FFFFFF;
    chk("lbu_noearly", resp_valid, 0);
    step();
    mem_rvalid = 0;
    chk("lbu_rdata", {resp_valid, resp_rdata}, {1'b1, 32'h00000080});
    step();

    // signed half load at 0x102
    issue(0, 2'd1, 0, 32'h102, 32'h0);
    step();
    req_valid = 0; mem_ready = 1;
    chk("lh_be", {mem_addr, mem_be}, {32'h100, 4'hC});
    step();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h80011234;
    step();
    mem_rvalid = 0;
    chk("lh_rdata", {resp_valid, resp_rdata}, {1'b1, 32'hFFFF8001});
    step();

    // misaligned word load at 0x102
    issue(0, 2'd2, 0, 32'h102, 32'h0);
    step();                                   // cycle 1
    req_valid = 0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    mem_ready = 1;
    chk("lw2_acc0", {mem_valid, mem_addr, mem_be}, {1'b1, 32'h100, 4'hC});
    step();                                   // cycle 2 WAIT0
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h33221100;
    step();                                   // cycle 3 ACC1
    mem_rvalid = 0; mem_ready = 1;
    chk("lw2_acc1", {mem_valid, mem_addr, mem_be}, {1'b1, 32'h104, 4'h3});
    step();                                   // cycle 4 WAIT1
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h77665544;
    chk("lw2_wait1", resp_valid, 0);
    step();                                   // cycle 5
    mem_rvalid = 0;
    chk("lw2_resp", {resp_valid, resp_err, resp_rdata}, {1'b1, 1'b0, 32'h55443322});
`else
    chk("lw2_err", {resp_valid, resp_err, mem_valid}, 3'b110);
    chk("lw2_rdata", resp_rdata, 0);
`endif
    step();

    // misaligned half store wrapping the address space
    issue(1, 2'd1, 0, 32'hFFFFFFFF, 32'h0000ABCD);
    step();                                   // cycle 1
    req_valid = 0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    mem_ready = 1;
    chk("sh2_acc0", {mem_valid, mem_we, mem_addr, mem_be}, {1'b1, 1'b1, 32'hFFFFFFFC, 4'h8});
    chk("sh2_wd0", mem_wdata, 32'hCD000000);
    step();                                   // cycle 2
    chk("sh2_acc1", {mem_valid, mem_we, mem_addr, mem_be}, {1'b1, 1'b1, 32'h00000000, 4'h1});
    chk("sh2_wd1", mem_wdata, 32'h000000AB);
    step();                                   // cycle 3
    mem_ready = 0;
    chk("sh2_resp", {resp_valid, resp_err}, 2'b10);
`else
    chk("sh2_err", {resp_valid, resp_err, mem_valid}, 3'b110);
`endif
    step();

    // illegal size
    issue(0, 2'd3, 0, 32'h40, 32'h0);
    step();                                   // cycle 1
    req_valid = 0;
    chk("ill_resp", {resp_valid, resp_err, mem_valid}, 3'b110);
    step();                                   // cycle 2
    chk("ill_done", {resp_valid, mem_valid, req_ready}, 3'b001);

    // reset while waiting for load data
    issue(0, 2'd2, 0, 32'h300, 32'h0);
    step();
    req_valid = 0; mem_ready = 1;
    chk("rw_acc0", {mem_valid, mem_addr}, {1'b1, 32'h300});
    step();                                   // WAIT0
    mem_ready = 0;
    chk("rw_wait", {req_ready, mem_valid}, 2'b00);
    rst = 1'b1;
    #1;
    chk("rw_abort", {req_ready, mem_valid, resp_valid}, 3'b100);
    step();
    rst = 1'b0;
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_noresp", {resp_valid, req_ready}, 2'b01);
    end
    mem_rvalid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
